// File: rtl/ahb2apb_bridge_p.sv
// AHB-to-APB bridge: one AHB slave port fanned out to NUM_SLAVES APB slaves.
// HADDR[SEL_LSB+:4] selects the APB slave; every bus-facing output is registered.
module ahb2apb_bridge_p #(
   parameter int NUM_SLAVES = 3,
   parameter int ADDR_W     = 32,
   parameter int SEL_LSB    = 12,
   parameter int TIMEOUT    = 256
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     HSEL,
   input  logic [ADDR_W-1:0]        HADDR,
   input  logic [1:0]               HTRANS,
   input  logic                     HWRITE,
   input  logic [2:0]               HSIZE,
   input  logic [31:0]              HWDATA,
   input  logic                     HREADYin,
   output logic [31:0]              HRDATA,
   output logic                     HREADYout,
   output logic [1:0]               HRESP,
   output logic [ADDR_W-1:0]        PADDR,
   output logic [31:0]              PWDATA,
   output logic [3:0]               PSTRB,
   output logic                     PWRITE,
   output logic [NUM_SLAVES-1:0]    PSEL,
   output logic                     PENABLE,
   input  logic [NUM_SLAVES*32-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]    PREADY,
   input  logic [NUM_SLAVES-1:0]    PSLVERR
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [2:0] {
      StIdle, StWdata, StSetup, StAccess, StDone, StErr1, StErr2
   } state_e;

   state_e                r_state;
   logic [ADDR_W-1:0]     r_addr;
   logic [2:0]            r_size;
   logic [NUM_SLAVES-1:0] r_sel;
   logic [CNT_W-1:0]      r_cnt;
   logic [31:0]           r_hrdata;
   logic                  r_hready;
   logic [1:0]            r_hresp;
   logic [ADDR_W-1:0]     r_paddr;
   logic [31:0]           r_pwdata;
   logic [3:0]            r_pstrb;
   logic                  r_pwrite;
   logic [NUM_SLAVES-1:0] r_psel;
   logic                  r_penable;

   logic [3:0]            w_idx;
   logic [NUM_SLAVES-1:0] w_sel_dec;
   logic [31:0]           w_prdata;
   logic                  w_oor;
   logic                  w_accept;
   logic                  w_ready;
   logic                  w_slverr;
   logic                  w_unused;

   assign w_idx    = HADDR[SEL_LSB +: 4];
   assign w_oor    = ~|w_sel_dec;
   assign w_accept = HSEL & HTRANS[1] & HREADYin & r_hready;
   assign w_ready  = |(PREADY & r_sel);
   assign w_slverr = |(PSLVERR & r_sel);
   assign w_unused = HTRANS[0];

   // Slave decode and read-data mux; an out-of-range index decodes to all zeros.
   always_comb begin
      w_sel_dec = '0;
      w_prdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_sel_dec[i] = (w_idx == 4'(i));
         w_prdata     = w_prdata | (PRDATA[32*i +: 32] & {32{r_sel[i]}});
      end
   end

   function automatic logic [3:0] write_strb(input logic [2:0] size, input logic [1:0] a);
      if (size == 3'd0) return 4'b0001 << a;
      if (size == 3'd1) return 4'b0011 << {a[1], 1'b0};
      return 4'b1111;
   endfunction

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= StIdle;
         r_addr    <= '0;
         r_size    <= '0;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_hrdata  <= '0;
         r_hready  <= 1'b1;
         r_hresp   <= RESP_OKAY;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_pwrite  <= 1'b0;
         r_psel    <= '0;
         r_penable <= 1'b0;
      end else begin
         case (r_state)
            StIdle, StDone, StErr2: begin
               r_hresp <= RESP_OKAY;
               if (w_accept) begin
                  r_addr   <= HADDR;
                  r_size   <= HSIZE;
                  r_sel    <= w_sel_dec;
                  r_hready <= 1'b0;
                  if (w_oor) begin
                     r_state <= StErr1;
                     r_hresp <= RESP_ERR;
                  end else if (HWRITE) begin
                     r_state <= StWdata;
                  end else begin
                     // Reads skip WDATA, so SETUP outputs come straight from the bus.
                     r_state  <= StSetup;
                     r_paddr  <= HADDR;
                     r_pwrite <= 1'b0;
                     r_pstrb  <= 4'b0000;
                     r_psel   <= w_sel_dec;
                  end
               end else begin
                  r_state  <= StIdle;
                  r_hready <= 1'b1;
               end
            end
            StWdata: begin
               r_state  <= StSetup;
               r_pwdata <= HWDATA;
               r_paddr  <= r_addr;
               r_pwrite <= 1'b1;
               r_pstrb  <= write_strb(r_size, r_addr[1:0]);
               r_psel   <= r_sel;
            end
            StSetup: begin
               r_state   <= StAccess;
               r_penable <= 1'b1;
               r_cnt     <= '0;
            end
            StAccess: begin
               if (w_ready) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  if (w_slverr) begin
                     r_state <= StErr1;
                     r_hresp <= RESP_ERR;
                  end else begin
                     r_state  <= StDone;
                     r_hready <= 1'b1;
                     if (!r_pwrite) r_hrdata <= w_prdata;
                  end
               end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                  r_state   <= StErr1;
                  r_hresp   <= RESP_ERR;
                  r_psel    <= '0;
                  r_penable <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StErr1: begin
               r_state  <= StErr2;
               r_hready <= 1'b1;
            end
            default: begin
               r_state  <= StIdle;
               r_hready <= 1'b1;
               r_hresp  <= RESP_OKAY;
            end
         endcase
      end
   end

   assign HRDATA    = r_hrdata;
   assign HREADYout = r_hready;
   assign HRESP     = r_hresp;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign PSTRB     = r_pstrb;
   assign PWRITE    = r_pwrite;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// Bench for ahb2apb_bridge_p: directed vector table, hand sequences for pipelining,
// idle transfers and reset, then random transfers checked against a transaction model.
module tb_ahb2apb_bridge_p;

   localparam int NS = 3;
   localparam int TO = 8;

   logic           HCLK = 1'b0;
   logic           HRESETn = 1'b1;
   logic           HSEL = 1'b0;
   logic [31:0]    HADDR = '0;
   logic [1:0]     HTRANS = 2'b00;
   logic           HWRITE = 1'b0;
   logic [2:0]     HSIZE = 3'b000;
   logic [31:0]    HWDATA = '0;
   logic           HREADYin = 1'b1;
   logic [31:0]    HRDATA;
   logic           HREADYout;
   logic [1:0]     HRESP;
   logic [31:0]    PADDR;
   logic [31:0]    PWDATA;
   logic [3:0]     PSTRB;
   logic           PWRITE;
   logic [NS-1:0]  PSEL;
   logic           PENABLE;
   logic [NS*32-1:0] PRDATA;
   logic [NS-1:0]  PREADY;
   logic [NS-1:0]  PSLVERR;

   logic [31:0] slv_rdata [NS];
   int          slv_wait = 0;
   logic        slv_err = 1'b0;
   int          acc_cnt;
   logic [31:0] model_rdata = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 HCLK = ~HCLK;

   ahb2apb_bridge_p #(
      .NUM_SLAVES (NS),
      .ADDR_W     (32),
      .SEL_LSB    (12),
      .TIMEOUT    (TO)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADYin  (HREADYin),
      .HRDATA    (HRDATA),
      .HREADYout (HREADYout),
      .HRESP     (HRESP),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PSTRB     (PSTRB),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   // APB slaves: ready once slv_wait ACCESS cycles have passed; error only with ready.
   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)     acc_cnt <= 0;
      else if (PENABLE) acc_cnt <= acc_cnt + 1;
      else              acc_cnt <= 0;
   end
   assign PREADY  = (acc_cnt >= slv_wait) ? {NS{1'b1}} : {NS{1'b0}};
   assign PSLVERR = PREADY & {NS{slv_err}};
   assign PRDATA  = {slv_rdata[2], slv_rdata[1], slv_rdata[0]};

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          wt;
      logic        se;
      logic [2:0]  e_psel;
      logic [3:0]  e_strb;
      int          e_stall;
      int          e_acc;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                               input logic [31:0] wdata, input int wt, input logic se,
                               input logic [2:0] psel, input logic [3:0] strb, input int stall,
                               input int acc, input logic err, input logic [31:0] rdata);
      vec_t v;
      v.addr = addr; v.wr = wr; v.size = size; v.wdata = wdata; v.wt = wt; v.se = se;
      v.e_psel = psel; v.e_strb = strb; v.e_stall = stall; v.e_acc = acc;
      v.e_err = err; v.e_rdata = rdata;
      return v;
   endfunction

   // Transaction-level model: cost of each phase in cycles, and the read-data history.
   function automatic vec_t ref_model(input vec_t v);
      vec_t r = v;
      int   idx = int'(v.addr[15:12]);
      bit   oor = (idx >= NS);
      bit   tmo = !oor && (v.wt >= TO);
      r.e_acc   = oor ? 0 : (tmo ? TO : v.wt + 1);
      r.e_err   = oor || tmo || v.se;
      r.e_stall = oor ? 1 : (v.wr ? 1 : 0) + 1 + r.e_acc + (r.e_err ? 1 : 0);
      r.e_psel  = oor ? 3'b000 : 3'(1 << idx);
      if (!v.wr)            r.e_strb = 4'b0000;
      else if (v.size == 0) r.e_strb = 4'(1 << v.addr[1:0]);
      else if (v.size == 1) r.e_strb = v.addr[1] ? 4'b1100 : 4'b0011;
      else                  r.e_strb = 4'b1111;
      if (!v.wr && !r.e_err) model_rdata = slv_rdata[idx];
      r.e_rdata = model_rdata;
      return r;
   endfunction

   task automatic run_xfer(input vec_t v, input string tag);
      int         stall = 0, acc = 0, setups = 0, errc = 0, guard = 0;
      logic [2:0] psel_or = '0;
      bit         done = 0;
      @(negedge HCLK);
      chk($sformatf("%s_ready_before", tag), HREADYout, 1);
      slv_wait = v.wt;
      slv_err  = v.se;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = v.wdata;
      while (!done && guard < 40) begin
         @(negedge HCLK);
         guard++;
         if (HREADYout) begin
            done = 1;
         end else begin
            stall++;
            psel_or = psel_or | PSEL;
            chk($sformatf("%s_psel_onehot0", tag), {31'b0, $onehot0(PSEL)}, 1);
            if (HRESP == 2'b01) errc++;
            if (PSEL != 0 && !PENABLE) begin
               setups++;
               chk($sformatf("%s_setup_psel", tag), PSEL, v.e_psel);
            end
            if (PENABLE) begin
               acc++;
               chk($sformatf("%s_acc_psel", tag), PSEL, v.e_psel);
               chk($sformatf("%s_acc_paddr", tag), PADDR, v.addr);
               chk($sformatf("%s_acc_pwrite", tag), PWRITE, v.wr);
               chk($sformatf("%s_acc_pstrb", tag), PSTRB, v.e_strb);
               if (v.wr) chk($sformatf("%s_acc_pwdata", tag), PWDATA, v.wdata);
            end
         end
      end
      chk($sformatf("%s_completed", tag), done, 1);
      chk($sformatf("%s_stall", tag), stall, v.e_stall);
      chk($sformatf("%s_access_cycles", tag), acc, v.e_acc);
      chk($sformatf("%s_setup_cycles", tag), setups, (v.e_psel != 0) ? 1 : 0);
      chk($sformatf("%s_psel_seen", tag), psel_or, v.e_psel);
      chk($sformatf("%s_err1_cycles", tag), errc, v.e_err ? 1 : 0);
      chk($sformatf("%s_hresp_final", tag), HRESP, v.e_err ? 2'b01 : 2'b00);
      chk($sformatf("%s_apb_idle_final", tag), {PSEL, PENABLE}, 0);
      chk($sformatf("%s_hrdata", tag), HRDATA, v.e_rdata);
   endtask

   initial begin
      vec_t v;
      int   guard;
      slv_rdata[0] = 32'h1357_9BDF;
      slv_rdata[1] = 32'hCAFE_F00D;
      slv_rdata[2] = 32'h2468_ACE0;

      //        addr           wr    sz     wdata          wt  se    psel    strb     st acc err rdata
      tbl[0] = mk(32'h0000_1004, 1'b0, 3'd0, 32'h0,          0, 1'b0, 3'b010, 4'b0000, 2, 1, 0, 32'hCAFE_F00D);
      tbl[1] = mk(32'h0000_0003, 1'b1, 3'd0, 32'h1122_3344,  0, 1'b0, 3'b001, 4'b1000, 3, 1, 0, 32'hCAFE_F00D);
      tbl[2] = mk(32'h0000_2000, 1'b0, 3'd2, 32'h0,          5, 1'b0, 3'b100, 4'b0000, 7, 6, 0, 32'h2468_ACE0);
      tbl[3] = mk(32'h0000_0008, 1'b0, 3'd2, 32'h0,          0, 1'b1, 3'b001, 4'b0000, 3, 1, 1, 32'h2468_ACE0);
      tbl[4] = mk(32'h0000_3000, 1'b0, 3'd2, 32'h0,          0, 1'b0, 3'b000, 4'b0000, 1, 0, 1, 32'h2468_ACE0);
      tbl[5] = mk(32'h0000_1010, 1'b0, 3'd2, 32'h0,         20, 1'b0, 3'b010, 4'b0000,10, 8, 1, 32'h2468_ACE0);
      tbl[6] = mk(32'h0000_1006, 1'b1, 3'd1, 32'hAABB_CCDD,  0, 1'b0, 3'b010, 4'b1100, 3, 1, 0, 32'h2468_ACE0);
      tbl[7] = mk(32'h0000_2000, 1'b1, 3'd2, 32'h0BAD_F00D,  0, 1'b0, 3'b100, 4'b1111, 3, 1, 0, 32'h2468_ACE0);
      tbl[8] = mk(32'h0000_0000, 1'b0, 3'd2, 32'h0,          2, 1'b0, 3'b001, 4'b0000, 4, 3, 0, 32'h1357_9BDF);
      tbl[9] = mk(32'h0000_1000, 1'b1, 3'd2, 32'h5555_AAAA,  0, 1'b1, 3'b010, 4'b1111, 4, 1, 1, 32'h1357_9BDF);

      #1 HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      chk("rst_hreadyout", HREADYout, 1);
      chk("rst_hresp", HRESP, 0);
      chk("rst_hrdata", HRDATA, 0);
      chk("rst_apb", {PADDR, PWDATA}, 0);
      chk("rst_ctrl", {PSTRB, PWRITE, PSEL, PENABLE}, 0);
      HRESETn = 1'b1;

      for (int i = 0; i < 10; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));
      model_rdata = tbl[9].e_rdata;

      // Non-transfers: BUSY, unselected, and HREADYin low must all be ignored.
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_1000; HWRITE = 1'b0;
      @(negedge HCLK);
      chk("busy_ignored", {HREADYout, HRESP, PSEL}, {1'b1, 2'b00, 3'b000});
      HSEL = 1'b0; HTRANS = 2'b10;
      @(negedge HCLK);
      chk("hsel0_ignored", {HREADYout, HRESP, PSEL}, {1'b1, 2'b00, 3'b000});
      HSEL = 1'b1; HREADYin = 1'b0;
      @(negedge HCLK);
      chk("hreadyin0_ignored", {HREADYout, HRESP, PSEL}, {1'b1, 2'b00, 3'b000});
      HSEL = 1'b0; HTRANS = 2'b00; HREADYin = 1'b1;

      // Back-to-back reads, the second presented during DONE.
      slv_wait = 0; slv_err = 1'b0;
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0010; HWRITE = 1'b0; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      guard = 0;
      do begin
         @(negedge HCLK);
         guard++;
      end while (!HREADYout && guard < 20);
      chk("b2b_first_done", HREADYout, 1);
      chk("b2b_first_rdata", HRDATA, slv_rdata[0]);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1020;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      chk("b2b_setup", {HREADYout, PSEL, PENABLE}, {1'b0, 3'b010, 1'b0});
      @(negedge HCLK);
      chk("b2b_access", {HREADYout, PSEL, PENABLE}, {1'b0, 3'b010, 1'b1});
      @(negedge HCLK);
      chk("b2b_second_done", {HREADYout, HRESP}, {1'b1, 2'b00});
      chk("b2b_second_rdata", HRDATA, slv_rdata[1]);
      model_rdata = slv_rdata[1];

      for (int k = 0; k < 40; k++) begin
         for (int s = 0; s < NS; s++) slv_rdata[s] = $urandom;
         v.addr        = $urandom;
         v.addr[15:12] = 4'($urandom_range(0, 4));
         v.wr          = 1'($urandom_range(0, 1));
         v.size        = 3'($urandom_range(0, 2));
         v.wdata       = $urandom;
         v.wt          = $urandom_range(0, 10);
         v.se          = ($urandom_range(0, 4) == 0);
         v             = ref_model(v);
         run_xfer(v, $sformatf("rnd%0d", k));
      end

      // Reset asserted mid-ACCESS takes effect before the next clock edge.
      slv_wait = 20; slv_err = 1'b0;
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_2000; HWRITE = 1'b0;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      guard = 0;
      do begin
         @(negedge HCLK);
         guard++;
      end while (!PENABLE && guard < 20);
      chk("mid_rst_in_access", PENABLE, 1);
      #2 HRESETn = 1'b0;
      #1;
      chk("mid_rst_hready_hresp", {HREADYout, HRESP}, {1'b1, 2'b00});
      chk("mid_rst_hrdata", HRDATA, 0);
      chk("mid_rst_paddr_pwdata", {PADDR, PWDATA}, 0);
      chk("mid_rst_ctrl", {PSTRB, PWRITE, PSEL, PENABLE}, 0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("post_rst_idle", {HREADYout, HRESP, PSEL, PENABLE}, {1'b1, 2'b00, 3'b000, 1'b0});
      model_rdata = '0;
      slv_rdata[2] = 32'hFACE_0002;
      v = mk(32'h0000_2004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 3'b000, 4'b0000, 0, 0, 0, 32'h0);
      v = ref_model(v);
      run_xfer(v, "post_rst_read");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb2apb_bridge_p.md
AHB2APB_BRIDGE_P -- requirements
Module: ahb2apb_bridge_p

Interface
REQ-001 The block SHALL have these parameters:
- NUM_SLAVES, default 3: number of APB slaves; legal range 1..16.
- ADDR_W, default 32: address width of HADDR and PADDR.
- SEL_LSB, default 12: LSB of the slave-index field in HADDR.
- TIMEOUT, default 256: maximum ACCESS cycles before the bridge forces an error; 0 disables the timeout.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- HCLK, in, 1: the single clock.
- HRESETn, in, 1: reset, asynchronous, active-low.
- HSEL, in, 1: bridge selected.
- HADDR, in, ADDR_W: AHB address.
- HTRANS, in, 2: AHB transfer type.
- HWRITE, in, 1: 1 = write.
- HSIZE, in, 3: transfer size.
- HWDATA, in, 32: write data.
- HREADYin, in, 1: bus ready.
- HRDATA, out, 32: read data.
- HREADYout, out, 1: bridge ready.
- HRESP, out, 2: 00 = OKAY, 01 = ERROR.
- PADDR, out, ADDR_W: APB address.
- PWDATA, out, 32: APB write data.
- PSTRB, out, 4: APB write strobes.
- PWRITE, out, 1: APB direction.
- PSEL, out, NUM_SLAVES: one-hot slave select.
- PENABLE, out, 1: APB access phase.
- PRDATA, in, NUM_SLAVES*32: read data; slave i occupies bits [32i+31:32i].
- PREADY, in, NUM_SLAVES: per-slave ready.
- PSLVERR, in, NUM_SLAVES: per-slave error.

Function
REQ-003 A transfer SHALL be accepted on a rising HCLK when HSEL=1, HTRANS[1]=1, HREADYin=1 and HREADYout=1; HADDR, HWRITE, HSIZE and idx=HADDR[SEL_LSB+:4] SHALL be registered on acceptance.
REQ-004 IDLE/BUSY transfers or HSEL=0 SHALL get a zero-wait OKAY response: HREADYout=1, HRESP=00, no APB activity.
REQ-005 States SHALL be IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-006 Transitions on an accepted transfer:
- from IDLE, DONE or ERR2: write -> WDATA; read -> SETUP; idx>=NUM_SLAVES -> ERR1.
- with no transfer accepted, DONE and ERR2 -> IDLE.
REQ-007 WDATA SHALL last one cycle with HREADYout=0, register HWDATA into PWDATA, then -> SETUP.
REQ-008 SETUP SHALL drive PSEL[idx]=1, PENABLE=0, PADDR=latched address, PWRITE=latched HWRITE, then -> ACCESS unconditionally.
REQ-009 ACCESS SHALL drive PSEL[idx]=1, PENABLE=1 and exit as follows:
- stay while PREADY[idx]=0;
- PREADY[idx]=1 with PSLVERR[idx]=0 -> DONE;
- PREADY[idx]=1 with PSLVERR[idx]=1 -> ERR1.
REQ-010 PSTRB SHALL be 0000 for reads; for writes it SHALL be decoded from latched HSIZE and HADDR[1:0]:
- byte: 0001<<HADDR[1:0];
- half: 0011<<{HADDR[1],0};
- word or larger: 1111.
REQ-011 On DONE entry after a read, HRDATA SHALL register PRDATA[idx]; HRDATA SHALL hold until the next completed read.
REQ-012 HREADYout SHALL be 0 in WDATA, SETUP, ACCESS and ERR1, and 1 in IDLE, DONE and ERR2.
REQ-013 HRESP SHALL be 01 in ERR1 and ERR2 (two-cycle ERROR response) and 00 in all other states.
REQ-014 An ACCESS cycle counter SHALL clear on ACCESS entry; when TIMEOUT!=0 and the count reaches TIMEOUT-1 with PREADY[idx]=0, the state SHALL go -> ERR1 with PSEL and PENABLE deasserted next cycle.
REQ-015 Out-of-range idx SHALL never assert any PSEL bit.
REQ-016 PSEL SHALL be one-hot or zero at all times; PENABLE=1 only while in ACCESS.
REQ-017 Latency:
- read, zero-wait slave: accept T0, SETUP T1, ACCESS T2, DONE T3 (HREADYout=1, HRDATA valid).
- write: one cycle more than read.
REQ-018 A pipelined transfer presented during DONE or ERR2 SHALL be accepted without an intervening IDLE cycle.

Reset
REQ-019 HRESETn=0 SHALL asynchronously force:
- state IDLE;
- HREADYout=1, HRESP=00, HRDATA=0;
- PADDR=0, PWDATA=0, PSTRB=0, PWRITE=0, PSEL=0, PENABLE=0;
- counter cleared.
REQ-020 Reset asserted mid-transfer (any state) SHALL abort the transfer with no completion response; after release the bridge SHALL be in IDLE.

Verification
REQ-021 Read, NUM_SLAVES=3, HADDR=0x0000_1004, slave 1 PRDATA=0xCAFE_F00D, PREADY=1 -> PSEL=010 at T1–T2, PENABLE at T2, HRDATA=0xCAFE_F00D with HREADYout=1 at T3.
REQ-022 Byte write, HADDR=0x0000_0003, HSIZE=000, HWDATA=0x1122_3344 -> PSEL=001, PWRITE=1, PSTRB=1000, PWDATA=0x1122_3344, HRESP=00.
REQ-023 Read to slave 2 with PREADY low for 5 ACCESS cycles -> HREADYout=0 for 7 cycles total, then DONE; PSEL and PENABLE stable throughout.
REQ-024 PSLVERR=1 with PREADY=1 on slave 0 -> HRESP=01 for two cycles, HREADYout 0 then 1; HADDR=0x0000_3000 (idx 3) -> ERR1 directly, PSEL stays 000.
REQ-025 TIMEOUT=8, PREADY held 0 -> exactly 8 ACCESS cycles, then ERROR response; HRESETn pulsed low during ACCESS -> all outputs at reset values immediately, before the next HCLK edge.
REQ-026 Back-to-back reads to slaves 0 then 1, second presented in DONE -> second SETUP in the cycle after DONE, no IDLE gap.
